// File: rtl/audio_out_fifo.sv
// rtl/audio_out_fifo.sv - stereo sample output buffer between moving-average filter and codec
//
// Ports:
//   clk, reset_n                      clock; synchronous active-low reset
//   in_write, in_left, in_right       push strobe and stereo pair from the filter
//   codec_write_ready                 codec output FIFO can accept a pair
//   codec_write                       one-cycle write pulse to the codec
//   codec_writedata_left/right        registered stereo pair, valid with codec_write
//   full, empty, count                occupancy, derived from the stored-pair count
//   overflow_cnt, underflow_cnt       saturating debug counters (dropped pushes, starved drains)
module audio_out_fifo #(
    parameter  int DATA_W = 24,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_write,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic              codec_write_ready,
    output logic              codec_write,
    output logic [DATA_W-1:0] codec_writedata_left,
    output logic [DATA_W-1:0] codec_writedata_right,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic [15:0]       overflow_cnt,
    output logic [15:0]       underflow_cnt
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    // Left sample in the upper half, right in the lower half, so a pair is never split.
    logic [2*DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W:0]     count_r;

    logic pop;
    logic push;
    logic overflow;
    logic underflow;

    // Occupancy comes from the count, never from pointer comparison, so it is
    // unambiguous at full (pointers equal) and tracks the post-edge count.
    assign count = count_r;
    assign full  = (count_r == FULL_COUNT);
    assign empty = (count_r == '0);

    // The ~codec_write term leaves a gap cycle after every write, which covers the
    // codec deasserting ready one cycle late.
    assign pop       = codec_write_ready & ~empty & ~codec_write;
    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    assign push      = in_write & (~full | pop);
    assign overflow  = in_write & full & ~pop;
    assign underflow = codec_write_ready & empty & ~codec_write;

    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= {in_left, in_right};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr                <= '0;
            wr_ptr                <= '0;
            count_r               <= '0;
            codec_write           <= 1'b0;
            codec_writedata_left  <= '0;
            codec_writedata_right <= '0;
            overflow_cnt          <= '0;
            underflow_cnt         <= '0;
        end else begin
            codec_write <= pop;

            if (pop) begin
                // On a simultaneous push at full wr_ptr == rd_ptr; this reads the
                // old entry before the write lands.
                {codec_writedata_left, codec_writedata_right} <= mem[rd_ptr];
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end

            if (push && !pop) begin
                count_r <= count_r + (ADDR_W + 1)'(1);
            end else if (pop && !push) begin
                count_r <= count_r - (ADDR_W + 1)'(1);
            end

            if (overflow && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end

            if (underflow && (underflow_cnt != 16'hFFFF)) begin
                underflow_cnt <= underflow_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_audio_out_fifo.sv
// tb/tb_audio_out_fifo.sv - scoreboard testbench for audio_out_fifo
module tb_audio_out_fifo;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              reset_n;
    logic              in_write;
    logic [DATA_W-1:0] in_left;
    logic [DATA_W-1:0] in_right;
    logic              codec_write_ready;
    logic              codec_write;
    logic [DATA_W-1:0] codec_writedata_left;
    logic [DATA_W-1:0] codec_writedata_right;
    logic              full;
    logic              empty;
    logic [4:0]        count;
    logic [15:0]       overflow_cnt;
    logic [15:0]       underflow_cnt;

    audio_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .in_write              (in_write),
        .in_left               (in_left),
        .in_right              (in_right),
        .codec_write_ready     (codec_write_ready),
        .codec_write           (codec_write),
        .codec_writedata_left  (codec_writedata_left),
        .codec_writedata_right (codec_writedata_right),
        .full                  (full),
        .empty                 (empty),
        .count                 (count),
        .overflow_cnt          (overflow_cnt),
        .underflow_cnt         (underflow_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a queue of stored pairs plus the "wrote last cycle" flag.
    logic [47:0] mq[$];
    logic [47:0] exp_q[$];
    bit          m_cw  = 1'b0;
    logic [15:0] m_ovf = '0;
    logic [15:0] m_unf = '0;

    always @(posedge clk) begin
        if (!reset_n) begin
            mq.delete();
            exp_q.delete();
            m_cw  = 1'b0;
            m_ovf = '0;
            m_unf = '0;
        end else begin
            bit was_full;
            bit was_empty;
            bit did_pop;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            did_pop   = codec_write_ready && !was_empty && !m_cw;
            if (did_pop) exp_q.push_back(mq.pop_front());
            if (in_write) begin
                if (!was_full || did_pop) mq.push_back({in_left, in_right});
                else if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
            end
            if (codec_write_ready && was_empty && !m_cw && m_unf != 16'hFFFF)
                m_unf = m_unf + 16'd1;
            m_cw = did_pop;
        end
    end

    // Monitor: compares every observable output against the model each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("codec_write", codec_write, m_cw);
            if (codec_write) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got %h expected none",
                             {codec_writedata_left, codec_writedata_right});
                end else begin
                    chk("write_data", {codec_writedata_left, codec_writedata_right}, exp_q.pop_front());
                end
            end
            chk("count", count, mq.size());
            chk("full", full, mq.size() == DEPTH);
            chk("empty", empty, mq.size() == 0);
            chk("overflow_cnt", overflow_cnt, m_ovf);
            chk("underflow_cnt", underflow_cnt, m_unf);
        end
    end

    task automatic cyc(input logic w, input logic [23:0] l, input logic [23:0] r, input logic rdy);
        in_write          = w;
        in_left           = l;
        in_right          = r;
        codec_write_ready = rdy;
        @(negedge clk);
    endtask

    logic [47:0] got[$];

    task automatic drain(input int max_cyc);
        got.delete();
        for (int c = 0; c < max_cyc; c++) begin
            cyc(1'b0, '0, '0, 1'b1);
            if (codec_write) got.push_back({codec_writedata_left, codec_writedata_right});
            if (empty && !codec_write) break;
        end
    endtask

    initial begin
        logic [23:0] v;
        logic [15:0] ovf0;

        // Reset held two edges with push and ready active.
        reset_n           = 1'b0;
        in_write          = 1'b1;
        in_left           = 24'h111111;
        in_right          = 24'h222222;
        codec_write_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_codec_write", codec_write, 0);
        chk("rst_data", {codec_writedata_left, codec_writedata_right}, 48'h0);
        chk("rst_ovf", overflow_cnt, 0);
        chk("rst_unf", underflow_cnt, 0);
        mon_en  = 1'b1;
        reset_n = 1'b1;
        cyc(1'b0, '0, '0, 1'b0);

        // Single pass-through: write appears after the following edge.
        cyc(1'b1, 24'h000123, 24'hFFFFF0, 1'b1);
        chk("pt_no_write_yet", codec_write, 0);
        chk("pt_count1", count, 1);
        cyc(1'b0, '0, '0, 1'b1);
        chk("pt_write", codec_write, 1);
        chk("pt_data", {codec_writedata_left, codec_writedata_right}, {24'h000123, 24'hFFFFF0});
        chk("pt_count0", count, 0);
        cyc(1'b0, '0, '0, 1'b1);
        chk("pt_single_pulse", codec_write, 0);

        // Fill and overflow.
        for (int i = 0; i <= 16; i++) begin
            v = 24'(i);
            cyc(1'b1, v, -v, 1'b0);
            if (i == 15) begin
                chk("fill_full", full, 1);
                chk("fill_count", count, 16);
            end
        end
        chk("fill_ovf", overflow_cnt, 1);
        drain(60);
        chk("fill_drain_n", got.size(), 16);
        for (int k = 0; k < got.size(); k++) begin
            v = 24'(k);
            chk("fill_order", got[k], {v, -v});
        end
        chk("fill_empty", empty, 1);

        // Push at full with a simultaneous pop.
        for (int i = 0; i < 16; i++) cyc(1'b1, 24'(100 + i), 24'(200 + i), 1'b0);
        ovf0 = overflow_cnt;
        cyc(1'b1, 24'h000777, 24'h000888, 1'b1);
        chk("pp_count", count, 16);
        chk("pp_write", codec_write, 1);
        chk("pp_ovf", overflow_cnt, ovf0);
        drain(60);
        chk("pp_drain_n", got.size(), 16);
        if (got.size() == 16) begin
            chk("pp_first", got[0], {24'd101, 24'd201});
            chk("pp_last", got[15], {24'h000777, 24'h000888});
        end

        // Underflow from a clean reset.
        reset_n = 1'b0;
        cyc(1'b0, '0, '0, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, '0, '0, 1'b1);
            chk("unf_no_write", codec_write, 0);
        end
        chk("unf_cnt", underflow_cnt, 5);

        // Reset mid-drain.
        for (int i = 0; i < 8; i++) cyc(1'b1, 24'(300 + i), 24'(400 + i), 1'b0);
        chk("md_count8", count, 8);
        cyc(1'b0, '0, '0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1);
        reset_n = 1'b0;
        cyc(1'b1, 24'h00005A, 24'h00005A, 1'b1);
        chk("md_codec_write", codec_write, 0);
        chk("md_count", count, 0);
        reset_n = 1'b1;
        cyc(1'b1, 24'h0000AA, 24'h0000BB, 1'b1);
        drain(20);
        chk("md_drain_n", got.size(), 1);
        if (got.size() >= 1) chk("md_first", got[0], {24'h0000AA, 24'h0000BB});

        // Randomized traffic with varying codec pacing.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 600; i++) begin
                cyc(1'($urandom_range(0, 1)), 24'($urandom), 24'($urandom),
                    1'($urandom_range(0, 3) < ph + 1));
            end
        end
        drain(100);
        chk("final_empty", empty, 1);
        chk("final_scoreboard", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
